// File: rtl/sram_stream_ctrl.sv
// sram_stream_ctrl
//   Streams write and read requests onto a single-port SRAM (port 0) and
//   returns read data through a 2-entry response FIFO.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   wr_valid/wr_ready            write request handshake
//   wr_addr, wr_data, wr_mask    write word address, data, byte enables
//   rd_valid/rd_ready            read request handshake
//   rd_addr                      read word address
//   resp_valid/resp_ready        read response handshake
//   resp_data                    read response data
//   csb0, web0                   SRAM chip select / write enable (active low)
//   wmask0, addr0, din0          SRAM byte mask, address, write data
//   dout0                        SRAM read data (valid one cycle after read)
module sram_stream_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_WMASKS-1:0] wr_mask,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    typedef enum logic {
        LAST_WR = 1'b0,
        LAST_RD = 1'b1
    } rr_e;

    rr_e                   r_last;
    logic                  r_inflight;
    logic [1:0]            r_count;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [DATA_WIDTH-1:0] r_din_hold;

    logic [2:0] w_occ;
    logic       w_rd_elig;
    logic       w_wr_fire;
    logic       w_rd_fire;
    logic       w_push;
    logic       w_pop;

    // A read is only eligible when its response is guaranteed a FIFO slot,
    // counting the one already travelling through the SRAM.
    assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_rd_elig = rd_valid && (w_occ < 3'd2);

    // Tie goes to the side that did not win last; rst_n gating keeps both
    // ready outputs low while reset is held.
    assign w_wr_fire = rst_n && wr_valid && (!w_rd_elig || (r_last == LAST_RD));
    assign w_rd_fire = rst_n && w_rd_elig && !(wr_valid && (r_last == LAST_RD));

    assign wr_ready = w_wr_fire;
    assign rd_ready = w_rd_fire;

    assign w_push = r_inflight;
    assign w_pop  = (r_count != 2'd0) && resp_ready;

    assign resp_valid = (r_count != 2'd0);
    assign resp_data  = r_mem[r_rptr];

    always_comb begin
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = r_addr_hold;
        din0   = r_din_hold;
        if (w_wr_fire) begin
            csb0   = 1'b0;
            web0   = 1'b0;
            wmask0 = wr_mask;
            addr0  = wr_addr;
            din0   = wr_data;
        end else if (w_rd_fire) begin
            csb0  = 1'b0;
            addr0 = rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= LAST_RD;
            r_inflight  <= 1'b0;
            r_count     <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_addr_hold <= '0;
            r_din_hold  <= '0;
        end else begin
            if (w_wr_fire) begin
                r_last      <= LAST_WR;
                r_addr_hold <= wr_addr;
                r_din_hold  <= wr_data;
            end else if (w_rd_fire) begin
                r_last      <= LAST_RD;
                r_addr_hold <= rd_addr;
            end
            r_inflight <= w_rd_fire;
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= dout0;
    end

endmodule

// File: tb/tb_sram_stream_ctrl.sv
module tb_sram_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, wr_ready;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        rd_valid, rd_ready;
    logic [9:0]  rd_addr;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [9:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_stream_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(10),
        .NUM_WMASKS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(dout0)
    );

    // Behavioural single-port SRAM: byte-masked write, registered read.
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        dout0 = 32'h0;
    end
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, passing one rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = '0; wr_data = '0; wr_mask = '0; rd_addr = '0;
    endtask

    // Single uncontended write, checked on the SRAM pins.
    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m; rd_valid = 1'b0;
        #1;
        check("wr_ready", {31'b0, wr_ready}, 32'd1);
        check("wr_pins", {18'b0, csb0, web0, wmask0, addr0}, {18'b0, 1'b0, 1'b0, m, a});
        check("wr_din", din0, d);
        next_cycle();
        wr_valid = 1'b0;
    endtask

    // Read with empty FIFO: response two cycles after the fire.
    task automatic do_read(input logic [9:0] a, input logic [31:0] exp, input string tag);
        rd_valid = 1'b1; rd_addr = a;
        #1;
        check({tag, "_rd_ready"}, {31'b0, rd_ready}, 32'd1);
        check({tag, "_rd_pins"}, {20'b0, csb0, web0, addr0}, {20'b0, 1'b0, 1'b1, a});
        next_cycle();
        rd_valid = 1'b0;
        #1;
        check({tag, "_lat1"}, {31'b0, resp_valid}, 32'd0);
        next_cycle();
        #1;
        check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, "_data"}, resp_data, exp);
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        resp_ready = 1'b1;
        idle_inputs();
        wr_valid = 1'b1; rd_valid = 1'b1;
        wr_addr = 10'h3AA; wr_data = 32'hFFFF_FFFF; wr_mask = 4'hF; rd_addr = 10'h155;
        #12;
        // Outputs while in reset, with requests pending.
        check("rst_ready", {30'b0, wr_ready, rd_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_pins", {16'b0, csb0, web0, wmask0, addr0}, {16'b0, 1'b1, 1'b1, 4'h0, 10'h0});
        check("rst_din", din0, 32'h0);
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        next_cycle();

        // Write then read back; also covers read-after-write in the next cycle.
        do_write(10'h005, 32'hDEADBEEF, 4'hF);
        do_read(10'h005, 32'hDEADBEEF, "wr_rd");
        #1;
        check("idle_hold", {20'b0, csb0, web0, addr0}, {20'b0, 1'b1, 1'b1, 10'h005});
        check("idle_din_hold", din0, 32'hDEADBEEF);
        check("drained", {31'b0, resp_valid}, 32'd0);
        next_cycle();

        // Byte mask merge at the top address.
        do_write(10'h3FF, 32'h11223344, 4'hF);
        do_write(10'h3FF, 32'hAABBCCDD, 4'h5);
        do_read(10'h3FF, 32'h11BB33DD, "mask");

        // Backpressure: preload four words.
        do_write(10'h010, 32'hA0A0_0010, 4'hF);
        do_write(10'h011, 32'hA0A0_0011, 4'hF);
        do_write(10'h012, 32'hA0A0_0012, 4'hF);
        do_write(10'h013, 32'hA0A0_0013, 4'hF);
        resp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 10'h010;
        #1; check("bp_acc0", {31'b0, rd_ready}, 32'd1);
        next_cycle();
        rd_addr = 10'h011;
        #1; check("bp_acc1", {31'b0, rd_ready}, 32'd1);
        next_cycle();
        rd_addr = 10'h012;
        #1; check("bp_block0", {31'b0, rd_ready}, 32'd0);
        check("bp_head0", resp_data, 32'hA0A0_0010);
        next_cycle();
        #1; check("bp_block1", {31'b0, rd_ready}, 32'd0);
        check("bp_stable", {31'b0, resp_valid}, 32'd1);
        check("bp_stable_data", resp_data, 32'hA0A0_0010);
        next_cycle();
        resp_ready = 1'b1;
        #1; check("bp_block2", {31'b0, rd_ready}, 32'd0);
        next_cycle();
        #1; check("bp_head1", resp_data, 32'hA0A0_0011);
        check("bp_acc2", {31'b0, rd_ready}, 32'd1);
        next_cycle();
        rd_addr = 10'h013;
        #1; check("bp_acc3", {31'b0, rd_ready}, 32'd1);
        check("bp_empty", {31'b0, resp_valid}, 32'd0);
        next_cycle();
        rd_valid = 1'b0;
        #1; check("bp_head2", resp_data, 32'hA0A0_0012);
        next_cycle();
        #1; check("bp_head3", resp_data, 32'hA0A0_0013);
        check("bp_head3_v", {31'b0, resp_valid}, 32'd1);
        next_cycle();
        #1; check("bp_done", {31'b0, resp_valid}, 32'd0);
        next_cycle();

        // Contention: last grant was a read, so the write wins first.
        wr_valid = 1'b1; wr_addr = 10'h020; wr_data = 32'h0000_2020; wr_mask = 4'hF;
        rd_valid = 1'b1; rd_addr = 10'h010;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("cont_grant%0d", c), {30'b0, wr_ready, rd_ready},
                  (c % 2 == 0) ? 32'd2 : 32'd1);
            check($sformatf("cont_csb%0d", c), {31'b0, csb0}, 32'd0);
            next_cycle();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) next_cycle();
        #1; check("cont_drained", {31'b0, resp_valid}, 32'd0);
        next_cycle();

        // Reset one cycle after a read fire discards the in-flight read.
        rd_valid = 1'b1; rd_addr = 10'h3FF;
        next_cycle();
        rd_valid = 1'b0;
        rst_n = 1'b0;
        #1; check("mid_rst_pins", {30'b0, csb0, web0}, 32'd3);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1; check($sformatf("post_rst_valid%0d", c), {31'b0, resp_valid}, 32'd0);
            next_cycle();
        end
        // Pointer reset: write wins the first tie.
        wr_valid = 1'b1; wr_addr = 10'h030; wr_data = 32'h3030_3030; wr_mask = 4'hF;
        rd_valid = 1'b1; rd_addr = 10'h005;
        #1; check("post_rst_tie", {30'b0, wr_ready, rd_ready}, 32'd2);
        next_cycle();
        wr_valid = 1'b0;
        do_read(10'h005, 32'hDEADBEEF, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
